// File: rtl/qspi_stream_reader.sv
// qspi_stream_reader: quad-output fast read (0x6B) streaming reader.
// Prefetches words into a small FIFO and stops spi_clk when it fills.
module qspi_stream_reader #(
  parameter  int WORD_W     = 18,
  parameter  int DUMMY_CYC  = 8,
  parameter  int FIFO_DEPTH = 4,
  parameter  int CS_GAP     = 2,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [23:0]       start_addr,
  output logic              busy,
  output logic              spi_clk,
  output logic              spi_cs_n,
  output logic [3:0]        spi_io_out,
  output logic [3:0]        spi_io_oe,
  input  logic [3:0]        spi_io_in,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [LVL_W-1:0]  fifo_level
);

  localparam int NIB   = (WORD_W + 3) / 4;
  localparam int ASM_W = NIB * 4;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int NC_W  = $clog2(NIB + 1);
  localparam int GAP_W = $clog2(CS_GAP + 1);
  localparam logic [7:0] CMD_QREAD = 8'h6B;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    CMD,
    ADDR,
    DUMMY,
    READ,
    PAUSE
  } state_e;

  state_e            state_q, state_d;
  logic [23:0]       addr_q, addr_d;
  logic [31:0]       sh_q, sh_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [NC_W-1:0]   nib_cnt_q, nib_cnt_d;
  logic [ASM_W-1:0]  asm_q, asm_d;
  logic              push_q, push_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_en_q, sclk_en_d;
  logic [3:0]        io_out_q, io_out_d;
  logic [3:0]        io_oe_q, io_oe_d;

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  cnt_q, lvl_nx;
  logic              full, push, pop, near_full;

  assign full  = cnt_q == LVL_W'(FIFO_DEPTH);
  assign push  = push_q & ~full;
  assign pop   = rd_valid & rd_ready;

  always_comb begin
    lvl_nx = cnt_q;
    unique case ({push, pop})
      2'b10:   lvl_nx = cnt_q + 1'b1;
      2'b01:   lvl_nx = cnt_q - 1'b1;
      default: lvl_nx = cnt_q;
    endcase
  end

  // the word completing now lands one edge later, so count it in
  assign near_full = ({1'b0, lvl_nx} + 1'b1)
                     >= (LVL_W+1)'(FIFO_DEPTH);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    gap_d     = gap_q;
    nib_cnt_d = nib_cnt_q;
    asm_d     = asm_q;
    push_d    = 1'b0;
    if (start) begin
      addr_d    = start_addr;
      state_d   = GAP;
      gap_d     = '0;
      nib_cnt_d = '0;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        GAP: begin
          if (gap_q == GAP_W'(CS_GAP - 1)) begin
            state_d   = CMD;
            sh_d      = {CMD_QREAD, addr_q};
            bit_cnt_d = '0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        CMD: begin
          sh_d = {sh_q[30:0], 1'b0};
          if (bit_cnt_q == 5'd7) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        ADDR: begin
          sh_d = {sh_q[30:0], 1'b0};
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d = '0;
            nib_cnt_d = '0;
            state_d   = (DUMMY_CYC == 0) ? READ : DUMMY;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        DUMMY: begin
          if (bit_cnt_q == 5'(DUMMY_CYC - 1)) begin
            state_d   = READ;
            nib_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        READ: begin
          asm_d = (asm_q << 4) | ASM_W'(spi_io_in);
          if (nib_cnt_q == NC_W'(NIB - 1)) begin
            nib_cnt_d = '0;
            push_d    = 1'b1;
            if (near_full) state_d = PAUSE;
          end else begin
            nib_cnt_d = nib_cnt_q + 1'b1;
          end
        end
        PAUSE: begin
          // wait for the parked push so the level seen is final
          if (!push_q && cnt_q < LVL_W'(FIFO_DEPTH))
            state_d = READ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cs_n_d    = 1'b1;
    sclk_en_d = 1'b0;
    io_oe_d   = 4'b1001;
    io_out_d  = 4'b1000;
    unique case (state_d)
      CMD, ADDR: begin
        cs_n_d    = 1'b0;
        sclk_en_d = 1'b1;
        io_out_d  = {3'b100, sh_d[31]};
      end
      DUMMY, READ: begin
        cs_n_d    = 1'b0;
        sclk_en_d = 1'b1;
        io_oe_d   = 4'b0000;
      end
      PAUSE: begin
        cs_n_d  = 1'b0;
        io_oe_d = 4'b0000;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      gap_q     <= '0;
      nib_cnt_q <= '0;
      asm_q     <= '0;
      push_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      sclk_en_q <= 1'b0;
      io_out_q  <= 4'b1000;
      io_oe_q   <= 4'b1001;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      gap_q     <= gap_d;
      nib_cnt_q <= nib_cnt_d;
      asm_q     <= asm_d;
      push_q    <= push_d;
      cs_n_q    <= cs_n_d;
      sclk_en_q <= sclk_en_d;
      io_out_q  <= io_out_d;
      io_oe_q   <= io_oe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= lvl_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= asm_q[WORD_W-1:0];
  end

  assign busy       = state_q != IDLE;
  assign spi_clk    = ~clk & sclk_en_q;
  assign spi_cs_n   = cs_n_q;
  assign spi_io_out = io_out_q;
  assign spi_io_oe  = io_oe_q;
  assign rd_data    = mem_q[rd_ptr_q];
  assign rd_valid   = cnt_q != '0;
  assign fifo_level = cnt_q;

endmodule

// File: tb/tb_qspi_stream_reader.sv
// tb_qspi_stream_reader: flash model plus word scoreboard for two
// parameter sets of qspi_stream_reader.
module tb_qspi_stream_reader;

  localparam int WA = 18, DA = 8, FA = 4, NA = 5;
  localparam int WB = 8,  DB = 0, FB = 2, NB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst_n_a = 1'b0, st_a = 1'b0, rdy_a = 1'b0;
  logic [23:0]   addr_a = '0;
  logic [3:0]    io_in_a = '0;
  logic          busy_a, sclk_a, cs_a, vld_a;
  logic [3:0]    out_a, oe_a;
  logic [WA-1:0] dat_a;
  logic [2:0]    lvl_a;

  logic          rst_n_b = 1'b0, st_b = 1'b0, rdy_b = 1'b0;
  logic [23:0]   addr_b = '0;
  logic [3:0]    io_in_b = '0;
  logic          busy_b, sclk_b, cs_b, vld_b;
  logic [3:0]    out_b, oe_b;
  logic [WB-1:0] dat_b;
  logic [1:0]    lvl_b;

  qspi_stream_reader #(
    .WORD_W(WA), .DUMMY_CYC(DA), .FIFO_DEPTH(FA), .CS_GAP(2)
  ) u_a (
    .clk(clk), .rst_n(rst_n_a), .start(st_a), .start_addr(addr_a),
    .busy(busy_a), .spi_clk(sclk_a), .spi_cs_n(cs_a),
    .spi_io_out(out_a), .spi_io_oe(oe_a), .spi_io_in(io_in_a),
    .rd_data(dat_a), .rd_valid(vld_a), .rd_ready(rdy_a),
    .fifo_level(lvl_a)
  );

  qspi_stream_reader #(
    .WORD_W(WB), .DUMMY_CYC(DB), .FIFO_DEPTH(FB), .CS_GAP(2)
  ) u_b (
    .clk(clk), .rst_n(rst_n_b), .start(st_b), .start_addr(addr_b),
    .busy(busy_b), .spi_clk(sclk_b), .spi_cs_n(cs_b),
    .spi_io_out(out_b), .spi_io_oe(oe_b), .spi_io_in(io_in_b),
    .rd_data(dat_b), .rd_valid(vld_b), .rd_ready(rdy_b),
    .fifo_level(lvl_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // word w of a stream whose nibbles run 1..F repeating
  function automatic logic [31:0] mword(int ww, int nib, int w);
    logic [63:0] acc;
    acc = '0;
    for (int k = 0; k < nib; k++)
      acc = (acc << 4) | 64'(((w * nib + k) % 15) + 1);
    return 32'(acc & ((64'd1 << ww) - 1));
  endfunction

  int p_a = 0, pulses_a = 0, p_b = 0, pulses_b = 0;
  logic [31:0] frame_a = '0, frame_b = '0;

  always @(posedge sclk_a or posedge cs_a) begin
    if (cs_a) p_a = 0;
    else begin
      pulses_a++;
      if (p_a < 32) frame_a = {frame_a[30:0], out_a[0]};
      if (p_a >= 32 + DA) io_in_a = 4'(((p_a - 32 - DA) % 15) + 1);
      p_a++;
    end
  end

  always @(posedge sclk_b or posedge cs_b) begin
    if (cs_b) p_b = 0;
    else begin
      pulses_b++;
      if (p_b < 32) frame_b = {frame_b[30:0], out_b[0]};
      if (p_b >= 32 + DB) io_in_b = 4'(((p_b - 32 - DB) % 15) + 1);
      p_b++;
    end
  end

  int widx_a = 0, widx_b = 0;

  always @(negedge clk) begin
    if (!rst_n_a || st_a) widx_a = 0;
    else if (vld_a && rdy_a) begin
      chk("A.word", 32'(dat_a), mword(WA, NA, widx_a));
      widx_a++;
    end
    chk("A.lvl_max", 32'(32'(lvl_a) <= FA), 1);
  end

  always @(negedge clk) begin
    if (!rst_n_b || st_b) widx_b = 0;
    else if (vld_b && rdy_b) begin
      chk("B.word", 32'(dat_b), mword(WB, NB, widx_b));
      widx_b++;
    end
    chk("B.lvl_max", 32'(32'(lvl_b) <= FB), 1);
  end

  initial begin
    int n, c0, p0, w0;
    logic [23:0] ra;
    tick(3);
    chk("A.rst_cs", cs_a, 1);
    chk("A.rst_oe", oe_a, 4'b1001);
    chk("A.rst_out", out_a, 4'b1000);
    chk("A.rst_vld", vld_a, 0);
    chk("A.rst_lvl", lvl_a, 0);
    chk("A.rst_busy", busy_a, 0);
    chk("B.rst_oe", oe_b, 4'b1001);
    chk("B.rst_busy", busy_b, 0);
    @(negedge clk);
    #1;
    chk("A.rst_sclk", sclk_a, 0);
    tick;
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    tick;

    rdy_a = 1'b1;
    st_a = 1'b1;
    addr_a = 24'h012345;
    tick;
    st_a = 1'b0;
    chk("A.busy", busy_a, 1);
    n = 0;
    while (cs_a && n < 20) begin n++; tick; end
    chk("A.gap", n, 2);
    c0 = cyc;
    n = 0;
    while (!vld_a && n < 200) begin n++; tick; end
    chk("A.first_valid", cyc - c0, 8 + 24 + DA + NA + 1);
    chk("A.frame", frame_a, {8'h6B, 24'h012345});
    w0 = widx_a;
    tick(50);
    chk("A.continuous", widx_a - w0, 50 / NA);

    rdy_a = 1'b0;
    n = 0;
    while (lvl_a != 3'(FA) && n < 100) begin n++; tick; end
    chk("A.lvl_full", lvl_a, FA);
    p0 = pulses_a;
    tick(8);
    chk("A.pause_sclk", pulses_a - p0, 0);
    chk("A.pause_cs", cs_a, 0);
    chk("A.pause_lvl", lvl_a, FA);
    rdy_a = 1'b1;
    tick;
    rdy_a = 1'b0;
    chk("A.pop_lvl", lvl_a, FA - 1);
    p0 = pulses_a;
    tick;
    chk("A.resume_wait", pulses_a - p0, 0);
    tick;
    chk("A.resume", pulses_a - p0, 1);

    repeat (300) begin
      rdy_a = 1'($urandom_range(0, 1));
      tick;
    end
    rdy_a = 1'b1;
    tick(60);

    rdy_a = 1'b0;
    tick(12);
    chk("A.pre_flush", 32'(lvl_a != 0), 1);
    st_a = 1'b1;
    addr_a = 24'h000100;
    tick;
    st_a = 1'b0;
    chk("A.flush_cs", cs_a, 1);
    chk("A.flush_lvl", lvl_a, 0);
    chk("A.flush_vld", vld_a, 0);
    rdy_a = 1'b1;
    n = 0;
    while (cs_a && n < 20) begin n++; tick; end
    chk("A.regap", n, 2);
    c0 = cyc;
    n = 0;
    while (!vld_a && n < 200) begin n++; tick; end
    chk("A.re_first", cyc - c0, 8 + 24 + DA + NA + 1);
    chk("A.re_frame", frame_a, {8'h6B, 24'h000100});
    tick(40);

    repeat ($urandom_range(1, 30)) begin
      rdy_a = 1'($urandom_range(0, 1));
      tick;
    end
    ra = 24'($urandom);
    st_a = 1'b1;
    addr_a = ra;
    tick;
    st_a = 1'b0;
    rdy_a = 1'b1;
    n = 0;
    while (!vld_a && n < 200) begin n++; tick; end
    chk("A.rnd_frame", frame_a, {8'h6B, ra});
    tick(30);

    ra = 24'($urandom);
    st_a = 1'b1;
    addr_a = ra;
    tick;
    st_a = 1'b0;
    n = 0;
    while (!(p_a == 18 && !cs_a) && n < 100) begin n++; tick; end
    chk("A.addr10", p_a, 18);
    chk("A.addr10_bit", out_a[0], ra[13]);
    rst_n_a = 1'b0;
    tick;
    chk("A.mrst_cs", cs_a, 1);
    chk("A.mrst_busy", busy_a, 0);
    chk("A.mrst_oe", oe_a, 4'b1001);
    chk("A.mrst_vld", vld_a, 0);
    p0 = pulses_a;
    tick(5);
    chk("A.mrst_sclk", pulses_a - p0, 0);
    rst_n_a = 1'b1;
    tick;

    ra = 24'($urandom);
    st_b = 1'b1;
    addr_b = ra;
    tick;
    st_b = 1'b0;
    n = 0;
    while (cs_b && n < 20) begin n++; tick; end
    chk("B.gap", n, 2);
    c0 = cyc;
    n = 0;
    while (!vld_b && n < 200) begin n++; tick; end
    chk("B.first_valid", cyc - c0, 8 + 24 + DB + NB + 1);
    chk("B.frame", frame_b, {8'h6B, ra});
    n = 0;
    while (lvl_b != 2'(FB) && n < 50) begin n++; tick; end
    chk("B.lvl_full", lvl_b, FB);
    p0 = pulses_b;
    tick(6);
    chk("B.pause_sclk", pulses_b - p0, 0);
    chk("B.pause_cs", cs_b, 0);
    repeat (200) begin
      rdy_b = 1'($urandom_range(0, 1));
      tick;
    end
    rdy_b = 1'b1;
    tick(20);
    chk("B.progress", 32'(widx_b > 20), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
